// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants: one-hot status codes, special icodes
// and the pipeline-stage state encoding.
package y86_pkg;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  localparam logic [3:0] ICODE_HALT = 4'h0;
  localparam logic [3:0] ICODE_NOP  = 4'h1;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  // Anything other than exactly AOK (including multi-bit codes) is an exception.
  function automatic logic stat_is_exc(input logic [3:0] stat);
    return (stat != STAT_AOK);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at all-ones; synchronous clear beats increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next-count selection: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Y86-64 pipeline-stage register with stall/bubble control, halt freeze on a
// latched exception, a sticky control-error flag and stall/bubble counters.
module pipe_stage_reg
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned CNT_W       = 16,
  parameter logic [3:0]  NOP_ICODE   = ICODE_NOP,
  parameter bit          HALT_FREEZE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              bubble,
  input  logic              clr_cnt,
  input  logic              in_valid,
  input  logic [3:0]        in_stat,
  input  logic [3:0]        in_icode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [3:0]        out_stat,
  output logic [3:0]        out_icode,
  output logic [DATA_W-1:0] out_data,
  output logic              halted,
  output logic              ctrl_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [0:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic [3:0]        stat_q, stat_d;
  logic [3:0]        icode_q, icode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ctrl_err_q, ctrl_err_d;
  logic              stall_inc_s, bubble_inc_s;

  // Next-state and next-contents selection for the stage.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    stat_d       = stat_q;
    icode_d      = icode_q;
    data_d       = data_q;
    ctrl_err_d   = ctrl_err_q;
    stall_inc_s  = 1'b0;
    bubble_inc_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (stall) begin
          stall_inc_s = 1'b1;
          ctrl_err_d  = ctrl_err_q | bubble;
        end else if (bubble) begin
          bubble_inc_s = 1'b1;
          valid_d      = 1'b0;
          stat_d       = STAT_AOK;
          icode_d      = NOP_ICODE;
          data_d       = '0;
        end else begin
          valid_d = in_valid;
          stat_d  = in_stat;
          icode_d = in_icode;
          data_d  = in_data;
          // Only a freshly loaded exception freezes; held entries were seen already.
          if (HALT_FREEZE && in_valid && stat_is_exc(in_stat)) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Stage contents, state and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      valid_q    <= 1'b0;
      stat_q     <= STAT_AOK;
      icode_q    <= NOP_ICODE;
      data_q     <= '0;
      ctrl_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      stat_q     <= stat_d;
      icode_q    <= icode_d;
      data_q     <= data_d;
      ctrl_err_q <= ctrl_err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (stall_inc_s),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (bubble_inc_s),
    .count (bubble_cnt)
  );

  assign out_valid = valid_q;
  assign out_stat  = stat_q;
  assign out_icode = icode_q;
  assign out_data  = data_q;
  assign halted    = (state_q == ST_HALTED);
  assign ctrl_err  = ctrl_err_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: instance A uses default parameters, instance B uses
// CNT_W=2 and HALT_FREEZE=0 for saturation and no-freeze cases.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_stall, a_bubble, a_clr, a_in_valid;
  logic [3:0]  a_in_stat, a_in_icode;
  logic [63:0] a_in_data;
  logic        a_out_valid, a_halted, a_ctrl_err;
  logic [3:0]  a_out_stat, a_out_icode;
  logic [63:0] a_out_data;
  logic [15:0] a_stall_cnt, a_bubble_cnt;

  logic        b_stall, b_bubble, b_clr, b_in_valid;
  logic [3:0]  b_in_stat, b_in_icode;
  logic [63:0] b_in_data;
  logic        b_out_valid, b_halted, b_ctrl_err;
  logic [3:0]  b_out_stat, b_out_icode;
  logic [63:0] b_out_data;
  logic [1:0]  b_stall_cnt, b_bubble_cnt;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_a (
    .clk(clk), .rst_n(rst_n), .stall(a_stall), .bubble(a_bubble), .clr_cnt(a_clr),
    .in_valid(a_in_valid), .in_stat(a_in_stat), .in_icode(a_in_icode), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_stat(a_out_stat), .out_icode(a_out_icode),
    .out_data(a_out_data), .halted(a_halted), .ctrl_err(a_ctrl_err),
    .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(64), .CNT_W(2), .NOP_ICODE(4'h1), .HALT_FREEZE(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .stall(b_stall), .bubble(b_bubble), .clr_cnt(b_clr),
    .in_valid(b_in_valid), .in_stat(b_in_stat), .in_icode(b_in_icode), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_stat(b_out_stat), .out_icode(b_out_icode),
    .out_data(b_out_data), .halted(b_halted), .ctrl_err(b_ctrl_err),
    .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_stall = 1'b0; a_bubble = 1'b0; a_clr = 1'b0; a_in_valid = 1'b0;
    a_in_stat = 4'b1000; a_in_icode = 4'h0; a_in_data = 64'h0;
    b_stall = 1'b0; b_bubble = 1'b0; b_clr = 1'b0; b_in_valid = 1'b0;
    b_in_stat = 4'b1000; b_in_icode = 4'h0; b_in_data = 64'h0;
    tick(); tick();

    chk("rst_valid",  {63'd0, a_out_valid}, 64'd0);
    chk("rst_stat",   {60'd0, a_out_stat},  64'h8);
    chk("rst_icode",  {60'd0, a_out_icode}, 64'h1);
    chk("rst_data",   a_out_data,           64'h0);
    chk("rst_halted", {63'd0, a_halted},    64'd0);
    chk("rst_cerr",   {63'd0, a_ctrl_err},  64'd0);
    chk("rst_scnt",   {48'd0, a_stall_cnt}, 64'd0);
    chk("rst_bcnt",   {48'd0, a_bubble_cnt}, 64'd0);

    rst_n = 1'b1;
    a_in_valid = 1'b1; a_in_stat = 4'b1000; a_in_icode = 4'h6; a_in_data = 64'h100;
    tick();
    chk("ld_valid",  {63'd0, a_out_valid}, 64'd1);
    chk("ld_stat",   {60'd0, a_out_stat},  64'h8);
    chk("ld_icode",  {60'd0, a_out_icode}, 64'h6);
    chk("ld_data",   a_out_data,           64'h100);
    chk("ld_halted", {63'd0, a_halted},    64'd0);

    a_stall = 1'b1;
    a_in_data = 64'h111; tick();
    a_in_data = 64'h222; tick();
    a_in_data = 64'h333; tick();
    chk("stall_data", a_out_data,            64'h100);
    chk("stall_scnt", {48'd0, a_stall_cnt},  64'd3);
    chk("stall_bcnt", {48'd0, a_bubble_cnt}, 64'd0);

    a_stall = 1'b0; a_bubble = 1'b1;
    tick();
    chk("bub_valid", {63'd0, a_out_valid}, 64'd0);
    chk("bub_stat",  {60'd0, a_out_stat},  64'h8);
    chk("bub_icode", {60'd0, a_out_icode}, 64'h1);
    chk("bub_data",  a_out_data,           64'h0);
    chk("bub_bcnt",  {48'd0, a_bubble_cnt}, 64'd1);

    a_bubble = 1'b0; a_in_icode = 4'h2; a_in_data = 64'h200;
    tick();
    chk("ld2_data", a_out_data, 64'h200);

    a_stall = 1'b1; a_bubble = 1'b1; a_in_data = 64'h2ff;
    tick();
    chk("sb_data", a_out_data,            64'h200);
    chk("sb_cerr", {63'd0, a_ctrl_err},   64'd1);
    chk("sb_scnt", {48'd0, a_stall_cnt},  64'd4);
    chk("sb_bcnt", {48'd0, a_bubble_cnt}, 64'd1);

    a_stall = 1'b0; a_bubble = 1'b0; a_in_icode = 4'h3; a_in_data = 64'h300;
    tick();
    chk("cerr_sticky", {63'd0, a_ctrl_err}, 64'd1);
    chk("ld3_data",    a_out_data,          64'h300);

    a_in_stat = 4'b0100; a_in_icode = 4'h0; a_in_data = 64'h400;
    tick();
    chk("hlt_halted", {63'd0, a_halted},   64'd1);
    chk("hlt_stat",   {60'd0, a_out_stat}, 64'h4);
    chk("hlt_data",   a_out_data,          64'h400);

    a_in_stat = 4'b1000; a_in_icode = 4'h9; a_in_data = 64'h999;
    tick();
    a_bubble = 1'b1; tick();
    a_bubble = 1'b0; a_stall = 1'b1; tick();
    a_stall = 1'b0; a_in_data = 64'haaa; tick();
    a_bubble = 1'b1; a_stall = 1'b1; tick();
    a_bubble = 1'b0; a_stall = 1'b0;
    chk("frz_valid",  {63'd0, a_out_valid}, 64'd1);
    chk("frz_stat",   {60'd0, a_out_stat},  64'h4);
    chk("frz_icode",  {60'd0, a_out_icode}, 64'h0);
    chk("frz_data",   a_out_data,           64'h400);
    chk("frz_scnt",   {48'd0, a_stall_cnt}, 64'd4);
    chk("frz_bcnt",   {48'd0, a_bubble_cnt}, 64'd1);
    chk("frz_halted", {63'd0, a_halted},    64'd1);

    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("hclr_scnt",   {48'd0, a_stall_cnt},  64'd0);
    chk("hclr_bcnt",   {48'd0, a_bubble_cnt}, 64'd0);
    chk("hclr_halted", {63'd0, a_halted},     64'd1);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_halted", {63'd0, a_halted},    64'd0);
    chk("arst_valid",  {63'd0, a_out_valid}, 64'd0);
    chk("arst_stat",   {60'd0, a_out_stat},  64'h8);
    chk("arst_icode",  {60'd0, a_out_icode}, 64'h1);
    chk("arst_data",   a_out_data,           64'h0);
    chk("arst_cerr",   {63'd0, a_ctrl_err},  64'd0);

    tick();
    rst_n = 1'b1;
    b_stall = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("b_sat_scnt", {62'd0, b_stall_cnt}, 64'd3);

    b_clr = 1'b1;
    tick();
    chk("b_clr_scnt", {62'd0, b_stall_cnt}, 64'd0);

    b_clr = 1'b0; b_stall = 1'b0;
    b_in_valid = 1'b1; b_in_stat = 4'b0010; b_in_icode = 4'h5; b_in_data = 64'h55;
    tick();
    chk("b_adr_halted", {63'd0, b_halted},   64'd0);
    chk("b_adr_stat",   {60'd0, b_out_stat}, 64'h2);

    b_in_stat = 4'b1000; b_in_icode = 4'h7; b_in_data = 64'h77;
    tick();
    chk("b_ld_data",   b_out_data,           64'h77);
    chk("b_ld_icode",  {60'd0, b_out_icode}, 64'h7);

    b_in_valid = 1'b0; b_in_stat = 4'b0110; b_in_icode = 4'h9; b_in_data = 64'h99;
    tick();
    chk("b_inv_valid", {63'd0, b_out_valid}, 64'd0);
    chk("b_inv_stat",  {60'd0, b_out_stat},  64'h6);
    chk("b_inv_icode", {60'd0, b_out_icode}, 64'h9);
    chk("b_inv_halted", {63'd0, b_halted},   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
